// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared CPU encodings, bus widths and bubble constants for the EX stage
package ex_stage_pkg;
  localparam int XLEN     = 32;
  localparam int PC_W     = 30;
  localparam int ALUOP_W  = 4;
  localparam int MEMOP_W  = 2;
  localparam int CTRLOP_W = 2;
  localparam int REG_W    = 5;
  localparam int EXP_W    = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_OP_NOP  = 4'd0,
    ALU_OP_AND  = 4'd1,
    ALU_OP_OR   = 4'd2,
    ALU_OP_XOR  = 4'd3,
    ALU_OP_ADDS = 4'd4,
    ALU_OP_ADDU = 4'd5,
    ALU_OP_SUBS = 4'd6,
    ALU_OP_SUBU = 4'd7,
    ALU_OP_SHRL = 4'd8,
    ALU_OP_SHLL = 4'd9,
    ALU_OP_MUL  = 4'd10
  } alu_op_e;

  localparam logic [EXP_W-1:0] ISA_EXP_NONE     = 3'd0;
  localparam logic [EXP_W-1:0] ISA_EXP_ILLEGAL  = 3'd1;
  localparam logic [EXP_W-1:0] ISA_EXP_SYSCALL  = 3'd2;
  localparam logic [EXP_W-1:0] ISA_EXP_OVERFLOW = 3'd3;

  localparam logic                BUBBLE_EN     = 1'b0;
  localparam logic                BUBBLE_GPRWE_ = 1'b1;
  localparam logic [MEMOP_W-1:0]  BUBBLE_MEMOP  = '0;
  localparam logic [CTRLOP_W-1:0] BUBBLE_CTRLOP = '0;
  localparam logic [EXP_W-1:0]    BUBBLE_EXP    = ISA_EXP_NONE;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic                en;
    logic                br;
    logic [MEMOP_W-1:0]  memop;
    logic [XLEN-1:0]     wrdata;
    logic [CTRLOP_W-1:0] ctrlop;
    logic [REG_W-1:0]    dst;
    logic                gprwe_;
    logic [EXP_W-1:0]    exp;
    logic [XLEN-1:0]     out;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '{
    pc: '0, en: BUBBLE_EN, br: 1'b0, memop: BUBBLE_MEMOP, wrdata: '0,
    ctrlop: BUBBLE_CTRLOP, dst: '0, gprwe_: BUBBLE_GPRWE_, exp: BUBBLE_EXP, out: '0
  };

  function automatic int mul_iters(input int bits_per_cyc);
    return XLEN / bits_per_cyc;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX pipeline bus, EX outputs and pipeline control for the EX stage
interface ex_stage_if;
  import ex_stage_pkg::*;
  logic                Stall;
  logic                Flush;
  logic [PC_W-1:0]     IDPC;
  logic                IDEn;
  logic [ALUOP_W-1:0]  IDALUOp;
  logic [XLEN-1:0]     IDALUIn0;
  logic [XLEN-1:0]     IDALUIn1;
  logic                IDBrFlag;
  logic [MEMOP_W-1:0]  IDMemOp;
  logic [XLEN-1:0]     IDMemWrData;
  logic [CTRLOP_W-1:0] IDCtrlOp;
  logic [REG_W-1:0]    IDDstAddr;
  logic                IDGPRWE_;
  logic [EXP_W-1:0]    IDExpCode;
  logic [XLEN-1:0]     EXFwdData;
  logic [PC_W-1:0]     EXPC;
  logic                EXEn;
  logic                EXBrFlag;
  logic [MEMOP_W-1:0]  EXMemOp;
  logic [XLEN-1:0]     EXMemWrData;
  logic [CTRLOP_W-1:0] EXCtrlOp;
  logic [REG_W-1:0]    EXDstAddr;
  logic                EXGPRWE_;
  logic [EXP_W-1:0]    EXExpCode;
  logic [XLEN-1:0]     EXOut;
  logic                MulBusy;

  modport master (
    output Stall, Flush, IDPC, IDEn, IDALUOp, IDALUIn0, IDALUIn1, IDBrFlag, IDMemOp,
           IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode,
    input  EXFwdData, EXPC, EXEn, EXBrFlag, EXMemOp, EXMemWrData, EXCtrlOp, EXDstAddr,
           EXGPRWE_, EXExpCode, EXOut, MulBusy
  );

  modport slave (
    input  Stall, Flush, IDPC, IDEn, IDALUOp, IDALUIn0, IDALUIn1, IDBrFlag, IDMemOp,
           IDMemWrData, IDCtrlOp, IDDstAddr, IDGPRWE_, IDExpCode,
    output EXFwdData, EXPC, EXEn, EXBrFlag, EXMemOp, EXMemWrData, EXCtrlOp, EXDstAddr,
           EXGPRWE_, EXExpCode, EXOut, MulBusy
  );
endinterface

// File: rtl/ex_mul.sv
// ex_mul: iterative unsigned shift-add multiplier, MUL_BITS_PER_CYC multiplier bits per BUSY cycle
module ex_mul import ex_stage_pkg::*; #(
  parameter int MUL_BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            i_req,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_in0,
  input  logic [XLEN-1:0] i_in1,
  output logic            o_done,
  output logic [XLEN-1:0] o_prod
);
  localparam int N = mul_iters(MUL_BITS_PER_CYC);

  mul_state_e      r_state, w_next;
  logic [XLEN-1:0] r_a, r_b, r_acc, w_pp;
  logic [5:0]      r_cnt;
  logic            w_start;

  assign w_start = (r_state == MUL_IDLE) && i_req && !i_flush;

  // state register
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) r_state <= MUL_IDLE;
    else r_state <= w_next;

  // next state: flush wins everywhere; stall only matters in DONE
  always_comb begin
    w_next = i_flush ? MUL_IDLE
           : w_start ? MUL_BUSY
           : (r_state == MUL_BUSY && r_cnt == 6'(N - 1)) ? MUL_DONE
           : (r_state == MUL_DONE && !i_stall) ? MUL_IDLE
           : r_state;
  end

  // partial product for the multiplier bits retired this cycle
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < MUL_BITS_PER_CYC; i++) w_pp = w_pp + (r_b[i] ? (r_a << i) : '0);
  end

  // operand latch on start, shift-add iteration while BUSY, discard on flush
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_a   <= i_in0;
      r_b   <= i_in1;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == MUL_BUSY) begin
      r_acc <= r_acc + w_pp;
      r_a   <= r_a << MUL_BITS_PER_CYC;
      r_b   <= r_b >> MUL_BITS_PER_CYC;
      r_cnt <= r_cnt + 6'd1;
    end

  assign o_done = (r_state == MUL_DONE);
  assign o_prod = r_acc;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- ALU, EX pipeline register, multiplier built only with EX_MUL_EN
module ex_stage import ex_stage_pkg::*; #(
  parameter int MUL_BITS_PER_CYC = 1
) (
  input logic       clk,
  input logic       reset_,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] w_a, w_b, w_sum, w_diff, w_alu;
  logic            w_ovf, w_mul_busy;
  ex_reg_t         r_ex, w_cap;

  assign w_a    = bus.IDALUIn0;
  assign w_b    = bus.IDALUIn1;
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;

`ifdef EX_MUL_EN
  logic            w_mul_req, w_mul_done;
  logic [XLEN-1:0] w_mul_prod;

  assign w_mul_req  = bus.IDEn && (bus.IDALUOp == ALU_OP_MUL);
  assign w_mul_busy = w_mul_req && !w_mul_done;

  ex_mul #(.MUL_BITS_PER_CYC(MUL_BITS_PER_CYC)) u_mul (
    .clk    (clk),
    .reset_ (reset_),
    .i_req  (w_mul_req),
    .i_stall(bus.Stall),
    .i_flush(bus.Flush),
    .i_in0  (w_a),
    .i_in1  (w_b),
    .o_done (w_mul_done),
    .o_prod (w_mul_prod)
  );
`else
  assign w_mul_busy = 1'b0;
`endif

  // ALU result, also forwarded to ID with no register in between
  always_comb begin
    w_alu = '0;
    case (bus.IDALUOp)
      ALU_OP_AND:               w_alu = w_a & w_b;
      ALU_OP_OR:                w_alu = w_a | w_b;
      ALU_OP_XOR:               w_alu = w_a ^ w_b;
      ALU_OP_ADDS, ALU_OP_ADDU: w_alu = w_sum;
      ALU_OP_SUBS, ALU_OP_SUBU: w_alu = w_diff;
      ALU_OP_SHRL:              w_alu = w_a >> w_b[4:0];
      ALU_OP_SHLL:              w_alu = w_a << w_b[4:0];
`ifdef EX_MUL_EN
      ALU_OP_MUL:               w_alu = w_mul_prod;
`endif
      default:                  w_alu = '0;
    endcase
  end

  assign w_ovf = (bus.IDALUOp == ALU_OP_ADDS) ? (w_a[XLEN-1] == w_b[XLEN-1]) && (w_sum[XLEN-1] != w_a[XLEN-1])
               : (bus.IDALUOp == ALU_OP_SUBS) ? (w_a[XLEN-1] != w_b[XLEN-1]) && (w_diff[XLEN-1] != w_a[XLEN-1])
               : 1'b0;

  // value taken on a normal advance; invalid entries and pending multiplies become bubbles
  always_comb begin
    w_cap = EX_BUBBLE;
    if (bus.IDEn && !w_mul_busy) begin
      w_cap.pc     = bus.IDPC;
      w_cap.en     = 1'b1;
      w_cap.br     = bus.IDBrFlag;
      w_cap.memop  = bus.IDMemOp;
      w_cap.wrdata = bus.IDMemWrData;
      w_cap.ctrlop = bus.IDCtrlOp;
      w_cap.dst    = bus.IDDstAddr;
      w_cap.gprwe_ = w_ovf ? 1'b1 : bus.IDGPRWE_;
      w_cap.exp    = w_ovf ? ISA_EXP_OVERFLOW : bus.IDExpCode;
      w_cap.out    = w_alu;
    end
  end

  // EX pipeline register: flush beats stall, stall holds everything
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) r_ex <= EX_BUBBLE;
    else if (bus.Flush) r_ex <= EX_BUBBLE;
    else if (!bus.Stall) r_ex <= w_cap;

  assign bus.EXFwdData   = w_alu;
  assign bus.MulBusy     = w_mul_busy;
  assign bus.EXPC        = r_ex.pc;
  assign bus.EXEn        = r_ex.en;
  assign bus.EXBrFlag    = r_ex.br;
  assign bus.EXMemOp     = r_ex.memop;
  assign bus.EXMemWrData = r_ex.wrdata;
  assign bus.EXCtrlOp    = r_ex.ctrlop;
  assign bus.EXDstAddr   = r_ex.dst;
  assign bus.EXGPRWE_    = r_ex.gprwe_;
  assign bus.EXExpCode   = r_ex.exp;
  assign bus.EXOut       = r_ex.out;
endmodule
